// File: rtl/ram_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_bus_pkg
// Purpose  : Types, constants and helpers shared by the RAM bus arbiter.
// Contents : arb_state_t    - arbiter FSM states (IDLE, ACCESS, ACK)
//            WAIT_CNT_W     - width of the wait-state counter
//            MAX_MASTERS    - upper bound on masters, sizes onehot_to_index
//            onehot_to_index- encodes a one-hot vector (up to 8 bits)
// Revision : 1.0 - initial release
// ============================================================================
package ram_bus_pkg;

  localparam int WAIT_CNT_W  = 4;
  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

  // Input must be one-hot or zero; OR-ing the set positions is then exact.
  function automatic logic [2:0] onehot_to_index(input logic [MAX_MASTERS-1:0] onehot);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (onehot[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_bus_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : ram_bus_priority_pick
// Purpose  : Combinational priority selector. The search begins at 'start'
//            and wraps from N_MASTERS-1 to 0; the first requester found wins.
//            With start tied to 0 this is plain lowest-index-wins priority.
// Ports    : req   [N_MASTERS] in  - request vector
//            start [IW]        in  - index where the search begins
//            gnt   [N_MASTERS] out - one-hot winner (0 when no request)
//            idx   [IW]        out - encoded winner index
//            valid             out - at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module ram_bus_priority_pick
  import ram_bus_pkg::*;
#(
  parameter  int N_MASTERS = 3,
  localparam int IW        = $clog2(N_MASTERS)
)(
  input  logic [N_MASTERS-1:0] req,
  input  logic [IW-1:0]        start,
  output logic [N_MASTERS-1:0] gnt,
  output logic [IW-1:0]        idx,
  output logic                 valid
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      int cand;
      cand = int'(start) + i;
      if (cand >= N_MASTERS) cand = cand - N_MASTERS;
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign idx   = IW'(onehot_to_index(MAX_MASTERS'(gnt)));
  assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/ram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_bus_arbiter
// Purpose  : Arbitrates N_MASTERS requesters onto the single external RAM
//            bus with programmable wait states and byte/word transfers.
//            Each transaction: IDLE (select+latch) -> ACCESS (WAIT_STATES+1
//            cycles, strobes active) -> ACK (one-cycle ack pulse) -> IDLE.
// Macro    : ARB_ROUND_ROBIN_EN - when defined, rotating priority starting
//            after the last granted master; otherwise fixed priority with
//            index 0 highest.
// Ports    : FCLK, RESET (async, active high)
//            req/we/word [N_MASTERS]  per-master request, write, word select
//            addr  [N_MASTERS*AW]     packed addresses
//            wdata [N_MASTERS*DW]     packed write data
//            gnt/ack [N_MASTERS]      owner / completion pulse
//            rdata [DW]               data of the last completed read
//            ABus, Read, Write, Word, outRamData, inRamData - RAM pins
// Revision : 1.0 - initial release
// ============================================================================
module ram_bus_arbiter
  import ram_bus_pkg::*;
#(
  parameter int N_MASTERS   = 3,
  parameter int AW          = 20,
  parameter int DW          = 16,
  parameter int WAIT_STATES = 1
)(
  input  logic                    FCLK,
  input  logic                    RESET,
  input  logic [N_MASTERS-1:0]    req,
  input  logic [N_MASTERS-1:0]    we,
  input  logic [N_MASTERS-1:0]    word,
  input  logic [N_MASTERS*AW-1:0] addr,
  input  logic [N_MASTERS*DW-1:0] wdata,
  output logic [N_MASTERS-1:0]    gnt,
  output logic [N_MASTERS-1:0]    ack,
  output logic [DW-1:0]           rdata,
  output logic [AW-1:0]           ABus,
  output logic                    Read,
  output logic                    Write,
  output logic                    Word,
  output logic [DW-1:0]           outRamData,
  input  logic [DW-1:0]           inRamData
);

  localparam int IW = $clog2(N_MASTERS);

  arb_state_t              state, state_nxt;
  logic [N_MASTERS-1:0]    gnt_r;
  logic [AW-1:0]           addr_r;
  logic [DW-1:0]           wdata_r;
  logic                    we_r, word_r;
  logic [WAIT_CNT_W-1:0]   cnt_r;

  logic [IW-1:0]           start;
  logic [N_MASTERS-1:0]    pick_gnt;
  logic [IW-1:0]           pick_idx;
  logic                    pick_valid;

  logic [AW-1:0]           sel_addr;
  logic [DW-1:0]           sel_wdata;
  logic                    sel_we, sel_word;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_r;
  logic [IW-1:0] last_idx;

  assign last_idx = IW'(onehot_to_index(MAX_MASTERS'(gnt_r)));

  // Pointer moves only on completion so a rotation step equals one transaction.
  always_ff @(posedge FCLK or posedge RESET) begin
    if (RESET) begin
      ptr_r <= '0;
    end else if (state == ACK) begin
      ptr_r <= (last_idx == IW'(N_MASTERS - 1)) ? '0 : last_idx + IW'(1);
    end
  end

  assign start = ptr_r;
`else
  assign start = '0;
`endif

  ram_bus_priority_pick #(
    .N_MASTERS (N_MASTERS)
  ) u_pick (
    .req   (req),
    .start (start),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Route the winner's transaction fields to the latch inputs.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_word  = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
        sel_we    = we[i];
        sel_word  = word[i];
      end
    end
  end

  always_ff @(posedge FCLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge FCLK or posedge RESET) begin
    if (RESET) begin
      gnt_r   <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      we_r    <= 1'b0;
      word_r  <= 1'b0;
      cnt_r   <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_r   <= pick_gnt;
            addr_r  <= sel_addr;
            wdata_r <= sel_wdata;
            we_r    <= sel_we;
            word_r  <= sel_word;
            cnt_r   <= WAIT_CNT_W'(WAIT_STATES);
          end
        end
        ACCESS: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - WAIT_CNT_W'(1);
          end else if (!we_r) begin
            rdata <= word_r ? inRamData : {{(DW-8){1'b0}}, inRamData[7:0]};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    Read      = 1'b0;
    Write     = 1'b0;
    Word      = 1'b0;
    gnt       = '0;
    ack       = '0;
    case (state)
      IDLE: begin
        if (pick_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        Read  = ~we_r;
        Write = we_r;
        Word  = word_r;
        gnt   = gnt_r;
        if (cnt_r == '0) state_nxt = ACK;
      end
      ACK: begin
        gnt       = gnt_r;
        ack       = gnt_r;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address holds through ACK and IDLE; only the strobes mark a live cycle.
  assign ABus       = addr_r;
  assign outRamData = word_r ? wdata_r : {{(DW-8){1'b0}}, wdata_r[7:0]};

endmodule
`default_nettype wire
